// File: rtl/iccm_uart_loader.sv
// ============================================================================
// Module   : iccm_uart_loader
// Purpose  : Boot loader that receives a UART 8N1 byte stream and packs it into
//            32-bit little-endian words. It writes the words into ICCM over a
//            req/gnt port and releases the core reset when the end-of-image
//            word arrives.
// Option   : define ICCM_LOADER_CKSUM_EN to require a trailing 32-bit checksum
//            word (sum of all written words) before the core reset is released.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iccm_uart_loader #(
    parameter int          CLKS_PER_BIT = 87,
    parameter int          ADDR_W       = 12,
    parameter logic [31:0] END_WORD     = 32'h0000_0FFF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_i,
    output logic              iccm_req_o,
    output logic              iccm_we_o,
    output logic [ADDR_W-1:0] iccm_addr_o,
    output logic [31:0]       iccm_wdata_o,
    input  logic              iccm_gnt_i,
    output logic              prog_done_o,
    output logic              core_rst_no,
    output logic              frame_err_o,
    output logic              overflow_o,
    output logic              cksum_err_o
);

    localparam int                c_CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(CLKS_PER_BIT / 2);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2,
        CKSUM = 2'd3
    } ctrl_state_t;

`ifdef ICCM_LOADER_CKSUM_EN
    localparam ctrl_state_t c_AFTER_END = CKSUM;
`else
    localparam ctrl_state_t c_AFTER_END = DONE;
`endif

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic               r_rx_meta;
    logic               r_rx_sync;
    rx_state_t          r_rx_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic [1:0]         r_byte_idx;
    logic [23:0]        r_word_buf;
    logic               r_frame_err;

    rx_state_t          w_rx_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [2:0]         w_bit_nxt;
    logic [7:0]         w_shift_nxt;
    logic               w_byte_valid;
    logic               w_frame_bad;
    logic               w_word_done;
    logic [31:0]        w_word;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rx_meta   <= 1'b1;
            r_rx_sync   <= 1'b1;
            r_rx_state  <= RX_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_byte_idx  <= '0;
            r_word_buf  <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_meta  <= rx_i;
            r_rx_sync  <= r_rx_meta;
            r_rx_state <= w_rx_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            if (w_frame_bad) begin
                r_frame_err <= 1'b1;
            end
            if (w_byte_valid) begin
                r_byte_idx <= r_byte_idx + 1'b1;
                case (r_byte_idx)
                    2'd0:    r_word_buf[7:0]   <= r_shift;
                    2'd1:    r_word_buf[15:8]  <= r_shift;
                    2'd2:    r_word_buf[23:16] <= r_shift;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_rx_nxt     = r_rx_state;
        w_cnt_nxt    = r_cnt;
        w_bit_nxt    = r_bit_idx;
        w_shift_nxt  = r_shift;
        w_byte_valid = 1'b0;
        w_frame_bad  = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (!r_rx_sync) begin
                    w_rx_nxt  = RX_START;
                    w_cnt_nxt = '0;
                    w_bit_nxt = '0;
                end
            end
            RX_START: begin
                if (r_cnt == c_CNT_HALF) begin
                    w_cnt_nxt = '0;
                    // A line back high at mid start bit was a glitch, not a frame
                    w_rx_nxt  = r_rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_rx_sync, r_shift[7:1]};
                    w_bit_nxt   = r_bit_idx + 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_rx_nxt = RX_STOP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_nxt    = '0;
                    w_rx_nxt     = RX_IDLE;
                    w_byte_valid = r_rx_sync;
                    w_frame_bad  = ~r_rx_sync;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_rx_nxt = RX_IDLE;
        endcase
    end

    assign w_word_done = w_byte_valid && (r_byte_idx == 2'd3);
    assign w_word      = {r_shift, r_word_buf};

    // ------------------------------------------------------------------
    // Write / completion control
    // ------------------------------------------------------------------
    ctrl_state_t       r_ctrl_state;
    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_overflow;
    logic              r_prog_done;
    logic              r_core_rst_n;

    ctrl_state_t       w_ctrl_nxt;
    logic              w_req_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [31:0]       w_wdata_nxt;
    logic              w_ovf_nxt;
    logic              w_is_end;

`ifdef ICCM_LOADER_CKSUM_EN
    logic [31:0] r_sum;
    logic        r_cksum_err;
    logic [31:0] w_sum_nxt;
    logic        w_cksum_err_nxt;
`endif

    assign w_is_end = (w_word == END_WORD);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ctrl_state <= LOAD;
            r_req        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_overflow   <= 1'b0;
            r_prog_done  <= 1'b0;
            r_core_rst_n <= 1'b0;
`ifdef ICCM_LOADER_CKSUM_EN
            r_sum        <= '0;
            r_cksum_err  <= 1'b0;
`endif
        end else begin
            r_ctrl_state <= w_ctrl_nxt;
            r_req        <= w_req_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_overflow   <= w_ovf_nxt;
            r_prog_done  <= (w_ctrl_nxt == DONE);
            r_core_rst_n <= (w_ctrl_nxt == DONE);
`ifdef ICCM_LOADER_CKSUM_EN
            r_sum        <= w_sum_nxt;
            r_cksum_err  <= w_cksum_err_nxt;
`endif
        end
    end

    always_comb begin
        w_ctrl_nxt  = r_ctrl_state;
        w_req_nxt   = r_req;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_ovf_nxt   = r_overflow;
`ifdef ICCM_LOADER_CKSUM_EN
        w_sum_nxt       = r_sum;
        w_cksum_err_nxt = r_cksum_err;
`endif
        case (r_ctrl_state)
            LOAD: begin
                if (w_word_done) begin
                    if (w_is_end) begin
                        w_ctrl_nxt = c_AFTER_END;
                    end else begin
                        w_wdata_nxt = w_word;
                        w_req_nxt   = 1'b1;
                        w_ctrl_nxt  = WRITE;
                    end
                end
            end
            WRITE: begin
                if (iccm_gnt_i) begin
                    w_addr_nxt = r_addr + 1'b1;
`ifdef ICCM_LOADER_CKSUM_EN
                    w_sum_nxt  = r_sum + r_wdata;
`endif
                    // A word landing on the grant cycle is chained straight into the next request
                    if (w_word_done && !w_is_end) begin
                        w_wdata_nxt = w_word;
                    end else begin
                        w_req_nxt  = 1'b0;
                        w_ctrl_nxt = (w_word_done && w_is_end) ? c_AFTER_END : LOAD;
                    end
                end else if (w_word_done) begin
                    w_ovf_nxt = 1'b1;
                end
            end
`ifdef ICCM_LOADER_CKSUM_EN
            CKSUM: begin
                if (w_word_done && !r_cksum_err) begin
                    if (w_word == r_sum) begin
                        w_ctrl_nxt = DONE;
                    end else begin
                        w_cksum_err_nxt = 1'b1;
                    end
                end
            end
`endif
            default: ;
        endcase
    end

    assign iccm_req_o   = r_req;
    assign iccm_we_o    = r_req;
    assign iccm_addr_o  = r_addr;
    assign iccm_wdata_o = r_wdata;
    assign prog_done_o  = r_prog_done;
    assign core_rst_no  = r_core_rst_n;
    assign frame_err_o  = r_frame_err;
    assign overflow_o   = r_overflow;
`ifdef ICCM_LOADER_CKSUM_EN
    assign cksum_err_o  = r_cksum_err;
`else
    assign cksum_err_o  = 1'b0;
`endif

endmodule

`default_nettype wire
